wave_sample_sequencer: RTL and testbench

//   Upstream feeder of the DDS interpolator. Steps a phase accumulator once per sample period.

---
 rtl/wave_sample_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_wave_sample_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wave_sample_sequencer.sv
// wave_sample_sequencer: phase-accumulator sample fetcher feeding the DDS interpolator.
// Steps a 32-bit phase accumulator once every N = 10^Mode clocks, reads the waveform
// lookup memory at acc[31 -: ADDR_W] and presents adjacent sample pairs with an
// Enable strobe. Optional feature: define PHASE_SYNC_EN to add the Sync_In phase reset.
module wave_sample_sequencer #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic [2:0]        Mode,
  input  logic              Run,
  input  logic [31:0]       PhaseInc,
`ifdef PHASE_SYNC_EN
  input  logic              Sync_In,
`endif
  output logic              Mem_Rd,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic [DATA_W-1:0] Out1,
  output logic [DATA_W-1:0] Out2,
  output logic              Enable,
  output logic              Busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         acc_q, acc_d;
  logic [13:0]         cnt_q, cnt_d;
  logic [MEM_LAT-1:0]  vpipe_q, vpipe_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   out1_q, out1_d;
  logic [DATA_W-1:0]   out2_q, out2_d;
  logic                enable_q, enable_d;

  logic [13:0]         period_max;
  logic                data_vld;
  logic                fetch;
  logic                sync_apply;
  logic                sync_q;
  logic                sync_in_w;

`ifdef PHASE_SYNC_EN
  logic sync_d;

  assign sync_in_w = Sync_In;

  // Sync request is held until the next fetch consumes it; in IDLE the accumulator is cleared directly.
  always_comb begin
    sync_d = 1'b0;
    if (state_q != S_IDLE) begin
      sync_d = (sync_q | Sync_In) & ~fetch;
    end
  end

  // Sync request flag.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
    end
  end
`else
  assign sync_q    = 1'b0;
  assign sync_in_w = 1'b0;
`endif

  // Terminal count of the period counter (N-1) for the selected mode.
  always_comb begin
    case (Mode)
      3'd0:    period_max = 14'd0;
      3'd1:    period_max = 14'd9;
      3'd2:    period_max = 14'd99;
      3'd3:    period_max = 14'd999;
      3'd4:    period_max = 14'd9999;
      default: period_max = 14'd0;
    endcase
  end

  assign data_vld = vpipe_q[MEM_LAT-1];

  // Next-state, fetch issue and sample-pair update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    enable_d   = 1'b0;
    fetch      = 1'b0;
    sync_apply = sync_q | sync_in_w;
    // The valid pipe follows the registered read strobe, so its last stage lines up with Mem_Data.
    vpipe_d    = (vpipe_q << 1) | MEM_LAT'(mem_rd_q);

    unique case (state_q)
      S_IDLE: begin
        if (Run) begin
          fetch   = 1'b1;
          state_d = S_PRIME;
        end else if (sync_in_w) begin
          acc_d = '0;
        end
      end
      S_PRIME: begin
        // Priming only loads the newest sample; no Enable for the first pair.
        if (data_vld) begin
          out2_d  = Mem_Data;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (data_vld) begin
          out1_d   = out2_q;
          out2_d   = Mem_Data;
          enable_d = 1'b1;
        end
        // >= so that shrinking N mid-count ticks on the very next cycle.
        if (!Run) begin
          state_d = S_DRAIN;
        end else if (cnt_q >= period_max) begin
          fetch = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 14'd1;
        end
      end
      S_DRAIN: begin
        if (data_vld) begin
          out1_d   = out2_q;
          out2_d   = Mem_Data;
          enable_d = 1'b1;
        end
        cnt_d = '0;
        if ((vpipe_q == '0) && !mem_rd_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fetch) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = sync_apply ? '0 : acc_q[31 -: ADDR_W];
      acc_d      = sync_apply ? PhaseInc : acc_q + PhaseInc;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      vpipe_q    <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      vpipe_q    <= vpipe_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      enable_q   <= enable_d;
    end
  end

  assign Mem_Rd   = mem_rd_q;
  assign Mem_Addr = mem_addr_q;
  assign Out1     = out1_q;
  assign Out2     = out2_q;
  assign Enable   = enable_q;
  assign Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_wave_sample_sequencer.sv
// Directed bench for wave_sample_sequencer with a 3-cycle-latency lookup memory model.
// Memory content: word at address a is 32'hD000_0000 | a.
module tb_wave_sample_sequencer;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  mode;
  logic        run;
  logic [31:0] inc;
  logic        sync_in;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic [31:0] out1;
  logic [31:0] out2;
  logic        enable;
  logic        busy;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  always #5 clk = ~clk;

  wave_sample_sequencer #(
    .ADDR_W (10),
    .DATA_W (32),
    .MEM_LAT(LAT)
  ) dut (
    .Fg_CLK  (clk),
    .RESETn  (rstn),
    .Mode    (mode),
    .Run     (run),
    .PhaseInc(inc),
`ifdef PHASE_SYNC_EN
    .Sync_In (sync_in),
`endif
    .Mem_Rd  (mem_rd),
    .Mem_Addr(mem_addr),
    .Mem_Data(mem_data),
    .Out1    (out1),
    .Out2    (out2),
    .Enable  (enable),
    .Busy    (busy)
  );

  // Synchronous lookup memory: data for the address presented at edge k appears after edge k+LAT-1.
  logic [31:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= 32'hD000_0000 | 32'(mem_addr);
    for (int unsigned i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mem_data = mpipe[LAT-1];

  function automatic logic [31:0] smp(input int a);
    return 32'hD000_0000 | 32'(a);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic goto(input int c);
    step(c - cyc);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; mode = 3'd0; run = 1'b0; inc = '0; sync_in = 1'b0;
    step(2);
    chk ("rst_out1", out1, 32'h0);
    chk ("rst_out2", out2, 32'h0);
    chkb("rst_en", enable, 1'b0);
    chkb("rst_rd", mem_rd, 1'b0);
    chkb("rst_busy", busy, 1'b0);

    // Mode 0, step of one address per sample.
    rstn = 1'b1; cyc = 0;
    mode = 3'd0; inc = 32'h0040_0000; run = 1'b1;
    step(1);
    chkb("prime_rd", mem_rd, 1'b1);
    chk ("prime_addr", 32'(mem_addr), 32'd0);
    chkb("prime_busy", busy, 1'b1);
    goto(5);
    chk ("primed_out2", out2, smp(0));
    chk ("primed_out1", out1, 32'h0);
    chkb("primed_en", enable, 1'b0);
    chkb("primed_rd", mem_rd, 1'b0);
    goto(6);  chkb("m0_rd1", mem_rd, 1'b1); chk("m0_addr1", 32'(mem_addr), 32'd1);
    goto(7);  chk ("m0_addr2", 32'(mem_addr), 32'd2);
    goto(9);  chkb("m0_en_pre", enable, 1'b0);
    goto(10); chkb("m0_en1", enable, 1'b1); chk("m0_o1_1", out1, smp(0)); chk("m0_o2_1", out2, smp(1));
    goto(11); chkb("m0_en2", enable, 1'b1); chk("m0_o1_2", out1, smp(1)); chk("m0_o2_2", out2, smp(2));
    goto(12); run = 1'b0;
    goto(16); chkb("m0_drain_en", enable, 1'b1); chk("m0_drain_o1", out1, smp(6)); chk("m0_drain_o2", out2, smp(7));
    goto(17); chkb("m0_idle_en", enable, 1'b0); chkb("m0_idle_busy", busy, 1'b0);
    chk("m0_hold_o1", out1, smp(6)); chk("m0_hold_o2", out2, smp(7));

    // Mode 1 restart from IDLE: accumulator continues at address 8.
    mode = 3'd1; run = 1'b1;
    goto(18); chkb("m1_prime_rd", mem_rd, 1'b1); chk("m1_prime_addr", 32'(mem_addr), 32'd8);
    goto(22); chk("m1_primed_o2", out2, smp(8)); chk("m1_primed_o1", out1, smp(6)); chkb("m1_primed_en", enable, 1'b0);
    goto(31); chkb("m1_rd_early", mem_rd, 1'b0);
    goto(32); chkb("m1_rd1", mem_rd, 1'b1); chk("m1_addr1", 32'(mem_addr), 32'd9);
    goto(36); chkb("m1_en1", enable, 1'b1); chk("m1_o1_1", out1, smp(8)); chk("m1_o2_1", out2, smp(9));
    goto(41); chkb("m1_en_gap", enable, 1'b0); chk("m1_hold_o2", out2, smp(9));
    goto(42); chkb("m1_rd2", mem_rd, 1'b1); chk("m1_addr2", 32'(mem_addr), 32'd10);
    goto(46); chkb("m1_en2", enable, 1'b1); chk("m1_o1_2", out1, smp(9)); chk("m1_o2_2", out2, smp(10));

    // Lengthen period mid-count, then shorten it while cnt=500.
    goto(47); mode = 3'd4;
    goto(52);  chkb("m4_no_tick", mem_rd, 1'b0);
    goto(542); chkb("m4_rd_before", mem_rd, 1'b0); mode = 3'd1;
    goto(543); chkb("m41_rd", mem_rd, 1'b1); chk("m41_addr", 32'(mem_addr), 32'd11);
    goto(547); chkb("m41_en", enable, 1'b1); chk("m41_o1", out1, smp(10)); chk("m41_o2", out2, smp(11));
    goto(552); chkb("m41_rd_gap", mem_rd, 1'b0);
    goto(553); chkb("m41_rd2", mem_rd, 1'b1); chk("m41_addr2", 32'(mem_addr), 32'd12);
    goto(557); chkb("m41_en2", enable, 1'b1); chk("m41_o2_2", out2, smp(12)); mode = 3'd0;

    // Two back-to-back reads, then stop: exactly two more Enables with LAT=3.
    goto(558); chk("dr_addr13", 32'(mem_addr), 32'd13);
    goto(559); chkb("dr_rd14", mem_rd, 1'b1); chk("dr_addr14", 32'(mem_addr), 32'd14); run = 1'b0;
    goto(560); chkb("dr_rd_off", mem_rd, 1'b0); chkb("dr_busy", busy, 1'b1);
    goto(561); chkb("dr_en_gap", enable, 1'b0);
    goto(562); chkb("dr_en1", enable, 1'b1); chk("dr_o1_1", out1, smp(12)); chk("dr_o2_1", out2, smp(13));
    goto(563); chkb("dr_en2", enable, 1'b1); chk("dr_o2_2", out2, smp(14)); chkb("dr_busy2", busy, 1'b1);
    goto(564); chkb("dr_en_off", enable, 1'b0); chkb("dr_idle", busy, 1'b0);
    chk("dr_hold_o1", out1, smp(13)); chk("dr_hold_o2", out2, smp(14));

    // Wrap: prime jumps acc from 15<<22 to 0xFFC00000, then 1023 -> 0 -> 1.
    inc = 32'hFC00_0000; run = 1'b1;
    goto(565); chk("wr_prime_addr", 32'(mem_addr), 32'd15); inc = 32'h0040_0000;
    goto(569); chk("wr_primed_o2", out2, smp(15)); chk("wr_primed_o1", out1, smp(13));
    goto(570); chk("wr_addr1023", 32'(mem_addr), 32'd1023);
    goto(571); chk("wr_addr0", 32'(mem_addr), 32'd0);
    goto(574); chkb("wr_en1", enable, 1'b1); chk("wr_o2_1", out2, smp(1023));
    goto(575); chkb("wr_en2", enable, 1'b1); chk("wr_o1_2", out1, smp(1023)); chk("wr_o2_2", out2, smp(0));
    goto(576); chkb("wr_en3", enable, 1'b1); chk("wr_o2_3", out2, smp(1));

    // Asynchronous reset mid-RUN.
    run = 1'b0; rstn = 1'b0;
    #1;
    chk ("mr_out1", out1, 32'h0);
    chk ("mr_out2", out2, 32'h0);
    chkb("mr_en", enable, 1'b0);
    chkb("mr_rd", mem_rd, 1'b0);
    chkb("mr_busy", busy, 1'b0);
    step(2);
    rstn = 1'b1;
    step(4);
    chkb("post_rst_rd", mem_rd, 1'b0);
    chkb("post_rst_busy", busy, 1'b0);
    chkb("post_rst_en", enable, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
